// File: rtl/image_copy_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : image_copy_dma_pkg
// Brief    : Shared FSM states, memory bank map and image constants for the
//            image copy DMA.
// Revision : 1.0 - initial release
// ============================================================================
package image_copy_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } dma_state_t;

    // Bank select lives in address bits [18:16]
    localparam logic [2:0] c_BANK_GENERAL       = 3'b000;
    localparam logic [2:0] c_BANK_IN_IMG_FIRST  = 3'b001;
    localparam logic [2:0] c_BANK_IN_IMG_LAST   = 3'b011;
    localparam logic [2:0] c_BANK_OUT_IMG_FIRST = 3'b100;
    localparam logic [2:0] c_BANK_OUT_IMG_LAST  = 3'b110;
    localparam logic [2:0] c_BANK_PERIPH        = 3'b111;

    localparam int unsigned IMG_PIXELS = 160000;

    function automatic logic [31:0] elem_addr(input logic [31:0] base,
                                              input logic [31:0] idx);
        return base + idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/image_copy_dma_counter.sv
`default_nettype none
// ============================================================================
// Module   : dma_counter
// Brief    : Element index counter with load, increment and last-element flag.
// Revision : 1.0 - initial release
// ============================================================================
module dma_counter #(
    parameter int LEN_W = 18
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_inc,
    output logic [LEN_W-1:0] o_idx,
    output logic             o_term
);

    logic [LEN_W-1:0] r_idx;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W:0]   w_idx_plus1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_idx <= '0;
            r_len <= '0;
        end else if (i_load) begin
            r_idx <= '0;
            r_len <= i_len;
        end else if (i_inc) begin
            r_idx <= r_idx + {{(LEN_W-1){1'b0}}, 1'b1};
        end
    end

    // Extra bit keeps idx+1 exact even when len spans the full field
    assign w_idx_plus1 = {1'b0, r_idx} + {{LEN_W{1'b0}}, 1'b1};
    assign o_term      = (w_idx_plus1 == {1'b0, r_len});
    assign o_idx       = r_idx;

endmodule
`default_nettype wire

// File: rtl/image_copy_dma.sv
`default_nettype none
// ============================================================================
// Module   : image_copy_dma
// Brief    : Byte-element memory-to-memory copy engine on the shared data bus.
// Revision : 1.0 - initial release
// ============================================================================
module image_copy_dma #(
    parameter int RD_LAT = 1,
    parameter int LEN_W  = 18
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start_i,
    input  logic [31:0]      src_base_i,
    input  logic [31:0]      dst_base_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             gnt_i,
    input  logic [31:0]      data_i,
    output logic             req_o,
    output logic [31:0]      address_o,
    output logic [31:0]      data_o,
    output logic             wren_o,
    output logic             busy_o,
    output logic             done_o
);

    import image_copy_dma_pkg::*;

    localparam logic [2:0] c_LAT_LAST = 3'(RD_LAT - 1);

    dma_state_t       r_state;
    dma_state_t       w_state_nxt;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [7:0]       r_byte;
    logic [2:0]       r_lat_cnt;
    logic             w_load;
    logic             w_inc;
    logic             w_term;
    logic             w_lat_last;
    logic [LEN_W-1:0] w_idx;
    logic [31:0]      w_idx_ext;
    logic             w_unused;

    dma_counter #(
        .LEN_W (LEN_W)
    ) u_counter (
        .CLK    (CLK),
        .RST    (RST),
        .i_load (w_load),
        .i_len  (len_i),
        .i_inc  (w_inc),
        .o_idx  (w_idx),
        .o_term (w_term)
    );

    assign w_idx_ext  = 32'(w_idx);
    assign w_lat_last = (r_lat_cnt == c_LAT_LAST);
    assign w_unused   = &{1'b0, data_i[31:8]};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_IDLE;
            r_src     <= '0;
            r_dst     <= '0;
            r_byte    <= '0;
            r_lat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_src <= src_base_i;
                r_dst <= dst_base_i;
            end
            // Read address is held RD_LAT cycles; data is taken on the last edge
            if (r_state == ST_RD) begin
                r_lat_cnt <= w_lat_last ? 3'd0 : r_lat_cnt + 3'd1;
                if (w_lat_last) begin
                    r_byte <= data_i[7:0];
                end
            end else begin
                r_lat_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_inc       = 1'b0;
        req_o       = 1'b0;
        wren_o      = 1'b0;
        address_o   = '0;
        data_o      = '0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = (len_i == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                req_o = 1'b1;
                if (gnt_i) begin
                    w_state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                req_o     = 1'b1;
                address_o = elem_addr(r_src, w_idx_ext);
                if (w_lat_last) begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_WR: begin
                req_o     = 1'b1;
                wren_o    = 1'b1;
                address_o = elem_addr(r_dst, w_idx_ext);
                data_o    = {24'h0, r_byte};
                w_inc     = 1'b1;
                // Grant is only re-examined here, at the element boundary
                if (w_term) begin
                    w_state_nxt = ST_DONE;
                end else if (gnt_i) begin
                    w_state_nxt = ST_RD;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy_o = (r_state != ST_IDLE);
    assign done_o = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_image_copy_dma.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_image_copy_dma
// Brief    : Self-checking bench for image_copy_dma against a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_image_copy_dma;

    localparam int LEN_W  = 18;
    localparam int MEM_AW = 20;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             start_i = 1'b0;
    logic             start2 = 1'b0;
    logic             gnt_i = 1'b0;
    logic [31:0]      src_base_i = '0;
    logic [31:0]      dst_base_i = '0;
    logic [LEN_W-1:0] len_i = '0;
    logic [31:0]      data1, data2, addr1, addr2, dout1, dout2;
    logic             req1, req2, wren1, wren2, busy1, busy2, done1, done2;

    logic [7:0] mem1   [0:(1<<MEM_AW)-1];
    logic [7:0] refmem [0:(1<<MEM_AW)-1];

    logic [31:0] wq_a[$], wq_d[$], wq2_a[$], wq2_d[$], rq2[$];
    logic [31:0] ex_a[$], ex_d[$];
    int n_done1, n_req1, n_done2;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        int          mode;     // 0 grant held, 2 grant pause, 3 start while busy
        int          exp_cyc;  // cycles from REQ entry to done_o
    } vec_t;
    vec_t tbl[8];

    always #5 CLK = ~CLK;

    // Upper data bits carry junk so the block must use only [7:0]
    assign data1 = {24'hA5C3E1, mem1[addr1[MEM_AW-1:0]]};
    assign data2 = {24'h5A3C1E, mem1[addr2[MEM_AW-1:0]]};

    image_copy_dma #(.RD_LAT(1), .LEN_W(LEN_W)) dut1 (
        .CLK(CLK), .RST(RST), .start_i(start_i), .src_base_i(src_base_i),
        .dst_base_i(dst_base_i), .len_i(len_i), .gnt_i(gnt_i), .data_i(data1),
        .req_o(req1), .address_o(addr1), .data_o(dout1), .wren_o(wren1),
        .busy_o(busy1), .done_o(done1)
    );

    image_copy_dma #(.RD_LAT(2), .LEN_W(LEN_W)) dut2 (
        .CLK(CLK), .RST(RST), .start_i(start2), .src_base_i(src_base_i),
        .dst_base_i(dst_base_i), .len_i(len_i), .gnt_i(gnt_i), .data_i(data2),
        .req_o(req2), .address_o(addr2), .data_o(dout2), .wren_o(wren2),
        .busy_o(busy2), .done_o(done2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Observes the bus mid-cycle, commits writes to memory, then advances one edge
    task automatic tick();
        @(negedge CLK);
        if (wren1) begin
            wq_a.push_back(addr1);
            wq_d.push_back(dout1);
            mem1[addr1[MEM_AW-1:0]] = dout1[7:0];
        end
        if (done1) n_done1++;
        if (req1) n_req1++;
        if (wren2) begin
            wq2_a.push_back(addr2);
            wq2_d.push_back(dout2);
        end
        if (req2 && !wren2 && addr2 != 32'h0) rq2.push_back(addr2);
        if (done2) n_done2++;
        @(posedge CLK);
        #1;
    endtask

    // Reference: ascending element-by-element copy over a plain byte array
    task automatic model_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
        logic [31:0] sa, da;
        logic [7:0]  b;
        ex_a.delete();
        ex_d.delete();
        for (int i = 0; i < len; i++) begin
            sa = src + 32'(i);
            da = dst + 32'(i);
            b  = refmem[sa[MEM_AW-1:0]];
            refmem[da[MEM_AW-1:0]] = b;
            ex_a.push_back(da);
            ex_d.push_back({24'h0, b});
        end
    endtask

    task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                              input int len, input bit use_model);
        wq_a.delete();
        wq_d.delete();
        n_done1 = 0;
        n_req1  = 0;
        if (use_model) model_copy(src, dst, len);
        gnt_i      = 1'b1;
        src_base_i = src;
        dst_base_i = dst;
        len_i      = LEN_W'(len);
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input int mode, output int cycles, output bit ok);
        int drop;
        bit dropped;
        drop = 0;
        dropped = 1'b0;
        cycles = 0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done1) begin
                ok = 1'b1;
                break;
            end
            tick();
            cycles++;
            case (mode)
                1: gnt_i = ($urandom_range(0, 3) != 0);
                2: begin
                    if (drop > 0) begin
                        check("pause_req", 64'(req1), 64'd1);
                        check("pause_wren", 64'(wren1), 64'd0);
                        drop--;
                        if (drop == 0) gnt_i = 1'b1;
                    end else if (!dropped && wren1 && wq_a.size() == 1) begin
                        gnt_i   = 1'b0;
                        drop    = 5;
                        dropped = 1'b1;
                    end
                end
                3: begin
                    if (cycles == 3) begin
                        start_i    = 1'b1;
                        src_base_i = 32'h0007_7000;
                        dst_base_i = 32'h0007_8000;
                        len_i      = LEN_W'(2);
                    end else if (cycles == 4) begin
                        start_i = 1'b0;
                    end
                end
                default: gnt_i = 1'b1;
            endcase
        end
    endtask

    task automatic verify(input string tag, input int len, input int cycles,
                          input int exp_cyc, input bit ok);
        int mism;
        int nmin;
        logic [31:0] a;
        check({tag, "_done_seen"}, 64'(ok), 64'd1);
        if (exp_cyc >= 0) check({tag, "_cycles"}, 64'(cycles), 64'(exp_cyc));
        check({tag, "_nwrites"}, 64'(wq_a.size()), 64'(ex_a.size()));
        nmin = (wq_a.size() < ex_a.size()) ? wq_a.size() : ex_a.size();
        mism = 0;
        for (int i = 0; i < nmin; i++)
            if (wq_a[i] !== ex_a[i] || wq_d[i] !== ex_d[i]) mism++;
        check({tag, "_write_seq"}, 64'(mism), 64'd0);
        mism = 0;
        for (int i = 0; i < ex_a.size(); i++) begin
            a = ex_a[i];
            if (mem1[a[MEM_AW-1:0]] !== refmem[a[MEM_AW-1:0]]) mism++;
        end
        check({tag, "_mem"}, 64'(mism), 64'd0);
        if (len == 0) check({tag, "_no_req"}, 64'(n_req1), 64'd0);
        tick();
        check({tag, "_idle_busy"}, 64'(busy1), 64'd0);
        check({tag, "_done_once"}, 64'(n_done1), 64'd1);
        check({tag, "_idle_addr"}, {32'h0, addr1}, 64'h0);
        check({tag, "_idle_data"}, {32'h0, dout1}, 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit ok;
        bit found;
        logic [7:0]  b;
        logic [31:0] s, d, e;
        int mism;

        for (int i = 0; i < (1 << MEM_AW); i++) begin
            b = 8'($urandom);
            mem1[i]   = b;
            refmem[i] = b;
        end
        for (int i = 0; i < 4; i++) begin
            mem1[20'h10000 + i]   = 8'(8'h11 * (i + 1));
            refmem[20'h10000 + i] = 8'(8'h11 * (i + 1));
        end

        tbl[0] = '{32'h0001_0000, 32'h0004_0000, 4, 0, 9};
        tbl[1] = '{32'h0002_0010, 32'h0005_0000, 1, 0, 3};
        tbl[2] = '{32'h0003_0100, 32'h0006_0200, 7, 0, 15};
        tbl[3] = '{32'h0000_1000, 32'h0000_1002, 5, 0, 11};
        tbl[4] = '{32'h0000_2005, 32'h0000_2000, 6, 0, 13};
        tbl[5] = '{32'h0001_0000, 32'h0004_0000, 0, 0, 0};
        tbl[6] = '{32'h0001_0100, 32'h0004_0100, 4, 2, 14};
        tbl[7] = '{32'h0002_0000, 32'h0005_0000, 6, 3, 13};

        // Reset state
        tick();
        tick();
        check("rst_req", 64'(req1), 64'd0);
        check("rst_wren", 64'(wren1), 64'd0);
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_done", 64'(done1), 64'd0);
        check("rst_addr", {32'h0, addr1}, 64'h0);
        check("rst_data", {32'h0, dout1}, 64'h0);
        check("rst_busy2", 64'(busy2), 64'd0);
        RST = 1'b1;
        tick();

        for (int r = 0; r < 8; r++) begin
            start_copy(tbl[r].src, tbl[r].dst, tbl[r].len, 1'b1);
            wait_done(tbl[r].mode, cyc, ok);
            verify($sformatf("vec%0d", r), tbl[r].len, cyc, tbl[r].exp_cyc, ok);
            if (r == 0) begin
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("vec0_addr%0d", i),
                          {32'h0, (wq_a.size() > i) ? wq_a[i] : 32'hxxxx_xxxx},
                          64'h0004_0000 + 64'(i));
                    check($sformatf("vec0_data%0d", i),
                          {32'h0, (wq_d.size() > i) ? wq_d[i] : 32'hxxxx_xxxx},
                          64'h11 * 64'(i + 1));
                end
            end
        end

        // Random transfers with a flickering grant
        for (int it = 0; it < 8; it++) begin
            s = 32'($urandom_range(0, (1 << MEM_AW) - 64));
            d = (it % 3 == 0) ? s + 32'($urandom_range(0, 3))
                              : 32'($urandom_range(0, (1 << MEM_AW) - 64));
            start_copy(s, d, $urandom_range(0, 24), 1'b1);
            wait_done(1, cyc, ok);
            verify($sformatf("rnd%0d", it), ex_a.size(), cyc, -1, ok);
        end

        // Reset while element 1 is being written
        start_copy(32'h0003_0000, 32'h0006_0000, 4, 1'b0);
        refmem[20'h60000] = refmem[20'h30000];
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (wren1 && wq_a.size() == 1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("rstwr_reached", 64'(found), 64'd1);
        RST = 1'b0;
        #1;
        check("rstwr_req", 64'(req1), 64'd0);
        check("rstwr_wren", 64'(wren1), 64'd0);
        check("rstwr_busy", 64'(busy1), 64'd0);
        check("rstwr_addr", {32'h0, addr1}, 64'h0);
        check("rstwr_data", {32'h0, dout1}, 64'h0);
        tick();
        tick();
        RST = 1'b1;
        for (int c = 0; c < 12; c++) tick();
        check("rstwr_nwrites", 64'(wq_a.size()), 64'd1);
        check("rstwr_busy_after", 64'(busy1), 64'd0);
        check("rstwr_no_done", 64'(n_done1), 64'd0);
        mism = 0;
        for (int i = 0; i < 4; i++)
            if (mem1[20'h60000 + i] !== refmem[20'h60000 + i]) mism++;
        check("rstwr_mem", 64'(mism), 64'd0);

        // Two-cycle read latency instance
        s = 32'h0001_0200;
        d = 32'h0004_0200;
        wq2_a.delete();
        wq2_d.delete();
        rq2.delete();
        n_done2    = 0;
        gnt_i      = 1'b1;
        src_base_i = s;
        dst_base_i = d;
        len_i      = LEN_W'(3);
        start2     = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 0;
        ok  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (done2) begin
                ok = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
        check("lat2_done_seen", 64'(ok), 64'd1);
        check("lat2_cycles", 64'(cyc), 64'd10);
        check("lat2_nreads", 64'(rq2.size()), 64'd6);
        mism = 0;
        for (int i = 0; i < 6; i++) begin
            e = s + 32'(i / 2);
            if (i >= rq2.size() || rq2[i] !== e) mism++;
        end
        check("lat2_read_hold", 64'(mism), 64'd0);
        check("lat2_nwrites", 64'(wq2_a.size()), 64'd3);
        mism = 0;
        for (int i = 0; i < 3; i++) begin
            e = s + 32'(i);
            if (i >= wq2_a.size() || wq2_a[i] !== d + 32'(i) ||
                wq2_d[i] !== {24'h0, refmem[e[MEM_AW-1:0]]}) mism++;
        end
        check("lat2_write_seq", 64'(mism), 64'd0);
        tick();
        check("lat2_idle_busy", 64'(busy2), 64'd0);
        check("lat2_done_once", 64'(n_done2), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
